// File: rtl/aes_op_unit.sv
// aes_op_unit: registered AES-128 round primitives (KeyExpansion, SubBytes, ShiftRows, MixColumns, AddRoundKey)
// Ports: clk, rst (sync, active-high); valid_in captures operand1/operand2/operation_select;
//        result is the registered 4x32-bit state, valid_out pulses one cycle after each capture.
//        Lane c is column c; row r of a lane sits at bits [31-8r -: 8].
module aes_op_unit #(
   parameter int regSize = 32,
   parameter int vecSize = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid_in,
   input  logic [vecSize-1:0][regSize-1:0]   operand1,
   input  logic [vecSize-1:0][regSize-1:0]   operand2,
   input  logic [2:0]                        operation_select,
   output logic [vecSize-1:0][regSize-1:0]   result,
   output logic                              valid_out
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   // Indexed directly by the round number; rounds 0 and 11..15 yield 00
   localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;
   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction
   logic [vecSize-1:0][regSize-1:0] result_d, result_q;
   logic                            valid_q;
   logic [3:0][31:0]                ke, sbx, sr, mc;
   logic [31:0]                     tmp;
   always_comb begin
      sr = '0;
      tmp = sub_word({operand1[3][23:0], operand1[3][31:24]}) ^ {RCON[operand2[0][3:0]], 24'h0};
      ke[0] = operand1[0] ^ tmp;
      ke[1] = operand1[1] ^ ke[0];
      ke[2] = operand1[2] ^ ke[1];
      ke[3] = operand1[3] ^ ke[2];
      for (int c = 0; c < 4; c++) begin
         sbx[c] = sub_word(operand1[c]);
         mc[c] = mix_col(operand1[c]);
         for (int r = 0; r < 4; r++)
            sr[c][31-8*r -: 8] = operand1[2'(c+r)][31-8*r -: 8];
      end
      result_d = operation_select == 3'b001 ? ke :
                 operation_select == 3'b010 ? sbx :
                 operation_select == 3'b011 ? sr :
                 operation_select == 3'b100 ? mc :
                 operation_select == 3'b101 ? operand1 ^ operand2 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         valid_q <= 1'b0;
      end else begin
         result_q <= valid_in ? result_d : result_q;
         valid_q <= valid_in;
      end
   end
   assign result = result_q;
   assign valid_out = valid_q;
endmodule

// File: tb/tb_aes_op_unit.sv
// tb_aes_op_unit: scoreboard bench for aes_op_unit against an arithmetic AES reference model
module tb_aes_op_unit;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic [3:0][31:0]  operand1 = '0;
   logic [3:0][31:0]  operand2 = '0;
   logic [2:0]        operation_select = '0;
   logic [3:0][31:0]  result;
   logic              valid_out;
   int                n_cmp = 0;
   int                n_bad = 0;
   logic [127:0]      exp_q[$];
   logic [7:0]        sbox_m[256];
   aes_op_unit dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .operand1(operand1), .operand2(operand2),
      .operation_select(operation_select), .result(result), .valid_out(valid_out));
   always #5 clk = ~clk;
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction
   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
   task automatic init_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = 8'h63;
         for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
         sbox_m[x] = s;
      end
   endtask
   function automatic logic [7:0] rcon(input int rnd);
      logic [7:0] rc = 8'h01;
      if (rnd < 1 || rnd > 10) return 8'h00;
      for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
      return rc;
   endfunction
   function automatic logic [127:0] lanes(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction
   function automatic logic [127:0] model(input logic [2:0] op, input logic [3:0][31:0] a, input logic [3:0][31:0] b);
      logic [7:0]       s[4][4];
      logic [7:0]       o[4][4];
      logic [3:0][31:0] res;
      logic [31:0]      t;
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[c][r] = a[c][31-8*r -: 8];
      case (op)
         3'd1: begin
            t = {sbox_m[s[3][1]], sbox_m[s[3][2]], sbox_m[s[3][3]], sbox_m[s[3][0]]};
            t = t ^ {rcon(int'(b[0][3:0])), 24'h0};
            res[0] = a[0] ^ t;
            for (int c = 1; c < 4; c++) res[c] = a[c] ^ res[c-1];
         end
         3'd2, 3'd3, 3'd4: begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  if (op == 3'd2) o[c][r] = sbox_m[s[c][r]];
                  else if (op == 3'd3) o[c][r] = s[(c + r) % 4][r];
                  else o[c][r] = gmul(8'h02, s[c][r]) ^ gmul(8'h03, s[c][(r + 1) % 4]) ^ s[c][(r + 2) % 4] ^ s[c][(r + 3) % 4];
                  res[c][31-8*r -: 8] = o[c][r];
               end
         end
         3'd5: res = a ^ b;
         default: res = '0;
      endcase
      return res;
   endfunction
   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", n, act, want);
      end
   endtask
   task automatic go_exp(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic [127:0] e);
      operation_select = op;
      operand1 = a;
      operand2 = b;
      valid_in = 1'b1;
      if (!rst) exp_q.push_back(e);
      @(negedge clk);
   endtask
   task automatic go(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
      go_exp(op, a, b, model(op, a, b));
   endtask
   task automatic idle();
      operation_select = 3'($urandom);
      operand1 = {$urandom, $urandom, $urandom, $urandom};
      operand2 = {$urandom, $urandom, $urandom, $urandom};
      valid_in = 1'b0;
      @(negedge clk);
   endtask
   logic [127:0] last_res = '0;
   always begin
      logic r, vi;
      logic [127:0] e;
      @(posedge clk);
      r = rst;
      vi = valid_in;
      #1;
      if (r) begin
         chk("rst_result", result, '0);
         chk("rst_valid", 128'(valid_out), '0);
         last_res = '0;
      end else begin
         chk("valid_out", 128'(valid_out), 128'(vi));
         if (vi) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 128'(1), 128'(0));
            else begin
               e = exp_q.pop_front();
               chk("result", result, e);
               last_res = e;
            end
         end else chk("hold", result, last_res);
      end
   end
   initial begin
      logic [127:0] mc_out, k;
      init_sbox();
      operation_select = 3'b101;
      operand1 = '1;
      valid_in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      go_exp(3'b010, lanes(32'h00000101, 32'h03030707, 32'h0f0f1f1f, 32'h3f3f7f7f),
             {$urandom, $urandom, $urandom, $urandom},
             lanes(32'h63637c7c, 32'h7b7bc5c5, 32'h7676c0c0, 32'h7575d2d2));
      go_exp(3'b011, lanes(32'h63637c7c, 32'h7b7bc5c5, 32'h7676c0c0, 32'h7575d2d2), '0,
             lanes(32'h637bc0d2, 32'h7b76d27c, 32'h76757cc5, 32'h7563c5c0));
      mc_out = lanes(32'h591ceea1, 32'hc28636d1, 32'hcaddaf02, 32'h4a27dca2);
      go_exp(3'b100, lanes(32'h637bc0d2, 32'h7b76d27c, 32'h76757cc5, 32'h7563c5c0), '0, mc_out);
      idle();
      idle();
      go_exp(3'b101, mc_out, {4{32'h61636363}},
             lanes(32'h387f8dc2, 32'ha3e555b2, 32'habbecc61, 32'h2b44bfc1));
      go_exp(3'b001, '0, lanes(32'h1, 0, 0, 0), {4{32'h62636363}});
      go_exp(3'b001, lanes(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c),
             {$urandom, $urandom, $urandom, $urandom, 4'h1},
             lanes(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
      go(3'b001, {$urandom, $urandom, $urandom, $urandom}, lanes(32'h0, 0, 0, 0));
      go_exp(3'b000, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, '0);
      go_exp(3'b110, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, '0);
      go_exp(3'b111, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, '0);
      for (int rd = 0; rd < 16; rd++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         go(3'b001, k, {$urandom, $urandom, $urandom, $urandom, 4'(rd)});
      end
      for (int i = 0; i < 400; i++) begin
         int sel = $urandom_range(0, 19);
         if (sel == 0) begin
            rst = 1'b1;
            go(3'($urandom_range(1, 5)), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            rst = 1'b0;
         end else if (sel < 4) idle();
         else go(3'($urandom), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      end
      valid_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 128'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
